// File: rtl/ldpc_vn_seq.sv
// ldpc_vn_seq: drives the shared control bus of the ldpc_vn array (load, DN/UP iterations, unload).
// Optional macro LDPC_VN_SEQ_EARLY_TERM_EN adds parity_ok / early_term for parity-based early exit.
module ldpc_vn_seq #(
   parameter int FOLDFACTOR = 1,
   parameter int MAX_ITER   = 30,
   parameter int PIPE_LAT   = 5,
   parameter int DRAIN      = 5,
   localparam int AW        = 7 + FOLDFACTOR
) (
   input  logic          clk,
   input  logic          rst,
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
   input  logic          parity_ok,
   output logic          early_term,
`endif
   input  logic          start,
   input  logic [AW-1:0] cfg_num_addr,
   input  logic [AW-1:0] cfg_num_active,
   input  logic          llr_in_valid,
   output logic          llr_out_valid,
   output logic          busy,
   output logic          done,
   output logic [7:0]    iter_count,
   output logic          llr_access,
   output logic [AW-1:0] llr_addr,
   output logic          llr_din_we,
   output logic          iteration,
   output logic          first_half,
   output logic          first_iteration,
   output logic          we_vnmsg,
   output logic          disable_vn,
   output logic [AW-1:0] addr_vn,
   output logic [3:0]    state_dbg
);

   // Handshake: start is a one-cycle request honoured only in IDLE; llr_in_valid has no ready,
   // every cycle it is high during LOAD consumes exactly one LLR (no backpressure, stalls unbounded).
   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_DRAIN_L, S_DN, S_DRAIN_D, S_UP, S_DRAIN_U, S_UNLOAD, S_DRAIN_O
   } state_t;

   state_t                state;
   logic [AW-1:0]         addr;
   logic [AW-1:0]         last_addr;
   logic [AW-1:0]         num_active;
   logic [7:0]            drain_cnt;
   logic [7:0]            drain_last;
   logic [PIPE_LAT-1:0]   vpipe;
   logic                  addr_last;
   logic                  exit_now;
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
   logic                  et_flag;
`endif

   assign state_dbg     = state;
   assign llr_out_valid = vpipe[PIPE_LAT-1];
   assign addr_last     = (addr == last_addr);

`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
   assign exit_now = (iter_count == 8'(MAX_ITER)) || parity_ok;
`else
   assign exit_now = (iter_count == 8'(MAX_ITER));
`endif

   // DRAIN_O runs one extra cycle: outputs lag the state by one, so the last read strobe
   // is still on the bus during the first DRAIN_O cycle.
   always_comb begin
      drain_last = 8'(DRAIN - 1);
      if (state == S_DRAIN_O) drain_last = 8'(PIPE_LAT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= S_IDLE;
         addr            <= '0;
         last_addr       <= '0;
         num_active      <= '0;
         drain_cnt       <= '0;
         vpipe           <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         iter_count      <= '0;
         llr_access      <= 1'b0;
         llr_addr        <= '0;
         llr_din_we      <= 1'b0;
         iteration       <= 1'b0;
         first_half      <= 1'b0;
         first_iteration <= 1'b0;
         we_vnmsg        <= 1'b0;
         disable_vn      <= 1'b0;
         addr_vn         <= '0;
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
         et_flag         <= 1'b0;
         early_term      <= 1'b0;
`endif
      end else begin
         vpipe <= (vpipe << 1) | PIPE_LAT'(llr_access & ~llr_din_we & first_half);
         done  <= 1'b0;
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
         early_term <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               if (start) begin
                  last_addr  <= cfg_num_addr - 1'b1;
                  num_active <= cfg_num_active;
                  addr       <= '0;
                  iter_count <= '0;
                  drain_cnt  <= '0;
                  busy       <= 1'b1;
                  state      <= S_LOAD;
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
                  et_flag    <= 1'b0;
`endif
               end
            end
            S_LOAD: begin
               llr_access <= 1'b1;
               llr_addr   <= addr;
               llr_din_we <= llr_in_valid;
               iteration  <= 1'b1;
               if (llr_in_valid) begin
                  if (addr_last) begin
                     addr  <= '0;
                     state <= S_DRAIN_L;
                  end else begin
                     addr <= addr + 1'b1;
                  end
               end
            end
            S_DN, S_UP: begin
               llr_access      <= 1'b0;
               llr_din_we      <= 1'b0;
               first_half      <= (state == S_DN);
               we_vnmsg        <= (state == S_UP);
               disable_vn      <= (state == S_UP) && (addr >= num_active);
               addr_vn         <= addr;
               iteration       <= iter_count[0];
               first_iteration <= (iter_count == 8'd0);
               if (addr_last) begin
                  addr <= '0;
                  if (state == S_DN) begin
                     state <= S_DRAIN_D;
                  end else begin
                     iter_count <= iter_count + 8'd1;
                     state      <= S_DRAIN_U;
                  end
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            S_UNLOAD: begin
               llr_access <= 1'b1;
               llr_din_we <= 1'b0;
               first_half <= 1'b1;
               we_vnmsg   <= 1'b0;
               llr_addr   <= addr;
               if (addr_last) begin
                  addr  <= '0;
                  state <= S_DRAIN_O;
               end else begin
                  addr <= addr + 1'b1;
               end
            end
            default: begin
               llr_access      <= 1'b0;
               llr_din_we      <= 1'b0;
               first_half      <= 1'b0;
               first_iteration <= 1'b0;
               we_vnmsg        <= 1'b0;
               disable_vn      <= 1'b0;
               llr_addr        <= '0;
               addr_vn         <= '0;
               addr            <= '0;
               drain_cnt       <= drain_cnt + 8'd1;
               if (drain_cnt == drain_last) begin
                  drain_cnt <= '0;
                  case (state)
                     S_DRAIN_L: state <= S_DN;
                     S_DRAIN_D: state <= S_UP;
                     S_DRAIN_U: begin
                        if (exit_now) begin
                           state <= S_UNLOAD;
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
                           et_flag <= (iter_count != 8'(MAX_ITER));
`endif
                        end else begin
                           state <= S_DN;
                        end
                     end
                     default: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
                        early_term <= et_flag;
`endif
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ldpc_vn_seq.sv
// Directed bench for ldpc_vn_seq: per-cycle phase trace and bus logs against hand-built expectations.
module tb_ldpc_vn_seq;
   localparam int AW       = 8;
   localparam int MAX_ITER = 2;
   localparam int PIPE_LAT = 5;
   localparam int DRAIN    = 5;
   typedef logic [31:0] w_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          llr_in_valid = 1'b0;
   logic [AW-1:0] cfg_num_addr = '0;
   logic [AW-1:0] cfg_num_active = '0;
   logic          llr_out_valid, busy, done, llr_access, llr_din_we, iteration;
   logic          first_half, first_iteration, we_vnmsg, disable_vn;
   logic [7:0]    iter_count;
   logic [AW-1:0] llr_addr, addr_vn;
   logic [3:0]    state_dbg;
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
   logic          parity_ok = 1'b0;
   logic          early_term;
`endif

   ldpc_vn_seq #(.FOLDFACTOR(1), .MAX_ITER(MAX_ITER), .PIPE_LAT(PIPE_LAT), .DRAIN(DRAIN)) dut (
      .clk(clk), .rst(rst),
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
      .parity_ok(parity_ok), .early_term(early_term),
`endif
      .start(start), .cfg_num_addr(cfg_num_addr), .cfg_num_active(cfg_num_active),
      .llr_in_valid(llr_in_valid), .llr_out_valid(llr_out_valid), .busy(busy), .done(done),
      .iter_count(iter_count), .llr_access(llr_access), .llr_addr(llr_addr),
      .llr_din_we(llr_din_we), .iteration(iteration), .first_half(first_half),
      .first_iteration(first_iteration), .we_vnmsg(we_vnmsg), .disable_vn(disable_vn),
      .addr_vn(addr_vn), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [63:0] outs;
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
   assign outs = {early_term, state_dbg, llr_out_valid, busy, done, iter_count, llr_access, llr_addr,
                  llr_din_we, iteration, first_half, first_iteration, we_vnmsg, disable_vn, addr_vn};
`else
   assign outs = {1'b0, state_dbg, llr_out_valid, busy, done, iter_count, llr_access, llr_addr,
                  llr_din_we, iteration, first_half, first_iteration, we_vnmsg, disable_vn, addr_vn};
`endif

   // scoreboard state
   int n_chk = 0;
   int n_pass = 0;
   w_t exp_q[$];
   w_t ph_q[$], we_log[$], dn_log[$], up_log[$], ul_log[$], ov_log[$], done_log[$], drv_q[$];
   int ul_cyc, ul_iter, done_iter, done_busy, done_et;
   int code;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic cmp_q(input string tag, input w_t g[$], input w_t e[$]);
      int errs = 0;
      chk({tag, "_len"}, 64'(g.size()), 64'(e.size()));
      for (int i = 0; i < g.size() && i < e.size(); i++)
         if (g[i] !== e[i]) errs++;
      chk({tag, "_err"}, 64'(errs), 64'd0);
   endtask

   // monitor: phase codes 3=load write, 4=unload read, 2=UP, 1=DN, 0=other
   always @(negedge clk) begin
      if (!rst) begin
         code = 0;
         if (llr_access && llr_din_we)      code = 3;
         else if (llr_access && first_half) code = 4;
         else if (we_vnmsg)                 code = 2;
         else if (first_half)               code = 1;
         if (busy) ph_q.push_back(w_t'(code));
         if (llr_din_we) we_log.push_back(w_t'(llr_addr));
         if (code == 1) dn_log.push_back({21'd0, iteration, first_iteration, disable_vn, addr_vn});
         if (code == 2) up_log.push_back({21'd0, iteration, first_iteration, disable_vn, addr_vn});
         if (code == 4) begin
            ul_log.push_back(w_t'(llr_addr));
            if (ul_cyc < 0) begin
               ul_cyc  = cyc;
               ul_iter = int'(iter_count);
            end
         end
         if (llr_out_valid) ov_log.push_back(w_t'(cyc));
         if (done) begin
            done_log.push_back(w_t'(cyc));
            done_iter = int'(iter_count);
            done_busy = int'(busy);
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
            done_et = int'(early_term);
`else
            done_et = 0;
`endif
         end
      end
   end

   task automatic clear_logs();
      ph_q.delete(); we_log.delete(); dn_log.delete(); up_log.delete();
      ul_log.delete(); ov_log.delete(); done_log.delete(); drv_q.delete();
      ul_cyc = -1; ul_iter = -1; done_iter = -1; done_busy = -1; done_et = -1;
   endtask

   // driver: start pulse plus serial LLR feed (pattern bits first, then all-valid)
   task automatic drive_run(input int na_cfg, input int nact, input logic [31:0] pat, input int plen,
                            input int n);
      int ones = 0;
      int i = 0;
      @(negedge clk);
      cfg_num_addr   = na_cfg[AW-1:0];
      cfg_num_active = nact[AW-1:0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (ones < n) begin
         llr_in_valid = (i < plen) ? pat[i] : 1'b1;
         drv_q.push_back(w_t'(llr_in_valid));
         if (llr_in_valid) ones++;
         i++;
         @(negedge clk);
      end
      llr_in_valid = 1'b0;
   endtask

   task automatic run_scn(input string tag, input int na_cfg, input int nact, input logic [31:0] pat,
                          input int plen, input bit poke, input bit pok, input int n_it);
      int n = (na_cfg == 0) ? (1 << AW) : na_cfg;
      bit got = 1'b0;
      int first = -1;
      int last = -1;
      w_t trim[$];
      clear_logs();
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
      parity_ok = pok;
`endif
      drive_run(na_cfg, nact, pat, plen, n);
      if (poke) begin
         repeat (3) @(negedge clk);
         cfg_num_addr = 8'd7;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      for (int k = 0; k < 20000 && !got; k++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      chk({tag, "_done_seen"}, 64'(got), 64'd1);
      repeat (2) @(negedge clk);
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
      parity_ok = 1'b0;
`endif

      for (int i = 0; i < ph_q.size(); i++)
         if (ph_q[i] != 0) begin
            if (first < 0) first = i;
            last = i;
         end
      if (first >= 0) for (int i = first; i <= last; i++) trim.push_back(ph_q[i]);

      exp_q.delete();
      foreach (drv_q[i]) exp_q.push_back(drv_q[i] != 0 ? 32'd3 : 32'd0);
      for (int d = 0; d < DRAIN; d++) exp_q.push_back(0);
      for (int it = 0; it < n_it; it++) begin
         for (int a = 0; a < n; a++) exp_q.push_back(1);
         for (int d = 0; d < DRAIN; d++) exp_q.push_back(0);
         for (int a = 0; a < n; a++) exp_q.push_back(2);
         for (int d = 0; d < DRAIN; d++) exp_q.push_back(0);
      end
      for (int a = 0; a < n; a++) exp_q.push_back(4);
      cmp_q({tag, "_phase"}, trim, exp_q);

      exp_q.delete();
      for (int a = 0; a < n; a++) exp_q.push_back(w_t'(a));
      cmp_q({tag, "_load_addr"}, we_log, exp_q);
      cmp_q({tag, "_unload_addr"}, ul_log, exp_q);

      exp_q.delete();
      for (int it = 0; it < n_it; it++)
         for (int a = 0; a < n; a++)
            exp_q.push_back(w_t'(((it & 1) << 10) | ((it == 0 ? 1 : 0) << 9) | a));
      cmp_q({tag, "_dn"}, dn_log, exp_q);

      exp_q.delete();
      for (int it = 0; it < n_it; it++)
         for (int a = 0; a < n; a++)
            exp_q.push_back(w_t'(((it & 1) << 10) | ((it == 0 ? 1 : 0) << 9) |
                                 ((a >= nact ? 1 : 0) << 8) | a));
      cmp_q({tag, "_up"}, up_log, exp_q);

      exp_q.delete();
      for (int a = 0; a < n; a++) exp_q.push_back(w_t'(ul_cyc + PIPE_LAT + a));
      cmp_q({tag, "_out_valid"}, ov_log, exp_q);

      chk({tag, "_iter_at_unload"}, 64'(ul_iter), 64'(n_it));
      chk({tag, "_done_count"}, 64'(done_log.size()), 64'd1);
      chk({tag, "_done_iter"}, 64'(done_iter), 64'(n_it));
      chk({tag, "_done_busy"}, 64'(done_busy), 64'd0);
      chk({tag, "_done_et"}, 64'(done_et), 64'(pok));
      if (done_log.size() > 0 && ov_log.size() > 0)
         chk({tag, "_done_after_valid"}, 64'(done_log[0] > ov_log[ov_log.size()-1]), 64'd1);
   endtask

   task automatic reset_mid_up();
      bit hit = 1'b0;
      clear_logs();
      drive_run(4, 4, 32'h1, 1, 4);
      for (int k = 0; k < 2000 && !hit; k++) begin
         @(negedge clk);
         if (we_vnmsg && addr_vn == 8'd2) hit = 1'b1;
      end
      chk("rstup_reached_up3", 64'(hit), 64'd1);
      rst = 1'b1;
      #1;
      chk("rstup_outs_zero", outs, 64'd0);
      @(negedge clk);
      chk("rstup_outs_held", outs, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rstup_idle_after", outs, 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outs", outs, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_outs", outs, 64'd0);

      run_scn("a3", 3, 2, 32'h1, 1, 1'b1, 1'b0, MAX_ITER);
      run_scn("b8_stall", 8, 5, 32'h2d, 6, 1'b0, 1'b0, MAX_ITER);
      reset_mid_up();
      run_scn("c1", 1, 1, 32'h1, 1, 1'b0, 1'b0, MAX_ITER);
      run_scn("d_full", 0, 200, 32'h1, 1, 1'b0, 1'b0, MAX_ITER);
`ifdef LDPC_VN_SEQ_EARLY_TERM_EN
      run_scn("e_early", 4, 4, 32'h1, 1, 1'b0, 1'b1, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
